// File: rtl/mcyc_ctrl_pkg.sv
// mcyc_ctrl_pkg: shared encodings and per-state control decode for the multicycle RV32I control path
package mcyc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word for a state; anything not set stays 0
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; c.pc_update = 1'b1; end
            S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
            S_MEMADR:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; end
            S_MEMREAD:  begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
            S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; c.mem_write = 1'b1; end
            S_EXECUTER: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALU_FUNCT; end
            S_EXECUTEI: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_FUNCT; end
            S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
            S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALUOUT; c.pc_update = 1'b1; end
            S_BEQ:      begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALU_SUB; c.result_src = RES_ALUOUT; c.branch = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcyc_imm_src_dec.sv
// mcyc_imm_src_dec: opcode to immediate-format select
module mcyc_imm_src_dec
    import mcyc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    assign imm_src = (op == OP_SW)  ? IMM_S :
                     (op == OP_BEQ) ? IMM_B :
                     (op == OP_JAL) ? IMM_J : IMM_I;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM sequencing RV32I instructions over 3-5 cycles
// Optional macro MCYC_BNE_EN: BEQ state also resolves BNE (funct3=001).
module multicycle_ctrl_fsm
    import mcyc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic [STATE_W-1:0] state_dbg
);

    state_t r_state;
    state_t w_next;
    ctrl_t  r_out;
    logic   w_en;
    logic   w_taken;

    // next-state selection; DECODE dispatches on opcode, stray encodings recover to FETCH
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE:   w_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                                 (op == OP_R)    ? S_EXECUTER :
                                 (op == OP_IALU) ? S_EXECUTEI :
                                 (op == OP_JAL)  ? S_JAL :
                                 (op == OP_BEQ)  ? S_BEQ : S_FETCH;
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // state and control word registered together so outputs come straight from flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_out   <= ctrl_of(S_FETCH);
        end else begin
            r_state <= w_next;
            r_out   <= ctrl_of(w_next);
        end
    end

`ifdef MCYC_BNE_EN
    assign w_taken = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0;
`else
    logic w_unused_funct3;
    assign w_unused_funct3 = ^funct3;
    assign w_taken = zero;
`endif

    // enables are dead during reset and in any encoding past JAL
    assign w_en       = ~rst & (r_state <= S_JAL);
    assign pc_write   = w_en & (r_out.pc_update | (r_out.branch & w_taken));
    assign mem_write  = w_en & r_out.mem_write;
    assign ir_write   = w_en & r_out.ir_write;
    assign reg_write  = w_en & r_out.reg_write;
    assign adr_src    = r_out.adr_src;
    assign result_src = r_out.result_src;
    assign alu_src_a  = r_out.alu_src_a;
    assign alu_src_b  = r_out.alu_src_b;
    assign alu_op     = r_out.alu_op;
    assign state_dbg  = STATE_W'(r_state);

    mcyc_imm_src_dec u_imm_dec (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized instruction stream checked against a per-instruction sequence model
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'h7f;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state_dbg;

    int checks = 0;
    int failures = 0;
    int exp_st = 0;
    int rw_cnt, mw_cnt, pc_cnt;

    multicycle_ctrl_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // instruction length in cycles
    function automatic int slen(input logic [6:0] o);
        case (o)
            LW: return 5;
            SW, RT, IA, JL: return 4;
            BQ: return 3;
            default: return 2;
        endcase
    endfunction

    // state visited at cycle k of an instruction
    function automatic int sst(input logic [6:0] o, input int k);
        logic [4:0][3:0] s;
        case (o)
            LW: s = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
            SW: s = {4'd0, 4'd5, 4'd2, 4'd1, 4'd0};
            RT: s = {4'd0, 4'd8, 4'd6, 4'd1, 4'd0};
            IA: s = {4'd0, 4'd8, 4'd7, 4'd1, 4'd0};
            JL: s = {4'd0, 4'd8, 4'd10, 4'd1, 4'd0};
            BQ: s = {4'd0, 4'd0, 4'd9, 4'd1, 4'd0};
            default: s = {4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        endcase
        return int'(s[k]);
    endfunction

    // expected outputs from the state's control table plus branch/imm/reset rules
    function automatic logic [14:0] model(input int st, input logic [6:0] o, input logic z,
                                          input logic [2:0] f, input logic r);
        logic pcu, br, adr, mw, ir, rw, tk, pc;
        logic [1:0] res, a, b, aop, imm;
        {pcu, br, adr, mw, ir, rw} = '0;
        {res, a, b, aop} = '0;
        case (st)
            0:  begin pcu = 1; ir = 1; b = 2; res = 2; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  begin adr = 1; end
            4:  begin res = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2; aop = 2; end
            7:  begin a = 2; b = 1; aop = 2; end
            8:  begin rw = 1; end
            9:  begin a = 2; aop = 1; br = 1; end
            10: begin a = 1; b = 2; pcu = 1; end
            default: ;
        endcase
`ifdef MCYC_BNE_EN
        tk = (f == 3'b000) ? z : (f == 3'b001) ? ~z : 1'b0;
`else
        tk = z;
`endif
        pc = pcu | (br & tk);
        if (r) {pc, mw, ir, rw} = '0;
        imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        return {pc, adr, mw, ir, res, a, b, aop, imm, rw};
    endfunction

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("ctrl_vec", {17'd0, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                           alu_src_b, alu_op, imm_src, reg_write},
              {17'd0, model(exp_st, op, zero, funct3, rst)});
        check("state_dbg", {28'd0, state_dbg}, exp_st);
    end

    // run n cycles (0 = whole instruction); zm<0 randomizes zero each cycle
    task automatic run(input logic [6:0] o, input logic [2:0] f, input int zm, input int n);
        int len;
        len = (n == 0) ? slen(o) : n;
        rw_cnt = 0; mw_cnt = 0; pc_cnt = 0;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            zero = (zm < 0) ? 1'($urandom) : zm[0];
            if (k == 0) begin op = o; funct3 = f; end
            exp_st = sst(o, k);
            #1;
            rw_cnt += int'(reg_write);
            mw_cnt += int'(mem_write);
            pc_cnt += int'(pc_write);
        end
    endtask

    // release reset between edges; the cycle after release must be FETCH, then an illegal op returns to FETCH
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        op = 7'h7f;
        exp_st = 0;
        #1;
        check("rel_ir_write", 32'(ir_write), 1);
        check("rel_pc_write", 32'(pc_write), 1);
        check("rel_alu_src_b", 32'(alu_src_b), 2);
        check("rel_state", 32'(state_dbg), 0);
        @(posedge clk);
        #1;
        exp_st = 1;
    endtask

    initial begin
        logic [6:0] ops[6] = '{LW, SW, RT, IA, JL, BQ};
        logic [6:0] o;
        release_reset();
        run(LW, 3'd0, -1, 0);
        check("lw_reg_write_cnt", rw_cnt, 1);
        check("lw_mem_write_cnt", mw_cnt, 0);
        run(SW, 3'd0, -1, 0);
        check("sw_mem_write_cnt", mw_cnt, 1);
        check("sw_reg_write_cnt", rw_cnt, 0);
        run(RT, 3'd0, -1, 0);
        check("r_reg_write_cnt", rw_cnt, 1);
        run(BQ, 3'd0, 1, 0);
        check("beq_taken_pc_cnt", pc_cnt, 2);
        run(BQ, 3'd0, 0, 0);
        check("beq_not_taken_pc_cnt", pc_cnt, 1);
        run(JL, 3'd0, -1, 0);
        check("jal_pc_cnt", pc_cnt, 2);
        check("jal_reg_write_cnt", rw_cnt, 1);
        run(7'h7f, 3'd0, -1, 0);
        check("ill_writes", rw_cnt + mw_cnt, 0);
`ifdef MCYC_BNE_EN
        run(BQ, 3'b001, 0, 0);
        check("bne_taken_pc_cnt", pc_cnt, 2);
        run(BQ, 3'b001, 1, 0);
        check("bne_not_taken_pc_cnt", pc_cnt, 1);
        run(BQ, 3'b100, -1, 0);
        check("b_other_f3_pc_cnt", pc_cnt, 1);
`else
        run(BQ, 3'b001, 1, 0);
        check("beq_f3_ignored_pc_cnt", pc_cnt, 2);
`endif
        // reset in the middle of MEMWRITE
        run(SW, 3'd0, -1, 4);
        check("memwrite_before_rst", 32'(mem_write), 1);
        rst = 1'b1;
        exp_st = 0;
        #1;
        check("memwrite_async_drop", 32'(mem_write), 0);
        check("state_async_reset", 32'(state_dbg), 0);
        repeat (2) @(posedge clk);
        release_reset();
        // random instruction stream with occasional mid-instruction reset
        for (int i = 0; i < 400; i++) begin
            int c;
            c = $urandom_range(0, 6);
            if (c < 6) o = ops[c];
            else begin
                o = 7'($urandom);
                while (o == LW || o == SW || o == RT || o == IA || o == JL || o == BQ) o = 7'($urandom);
            end
            if (i % 37 == 36) begin
                run(o, 3'($urandom), -1, $urandom_range(1, slen(o)));
                rst = 1'b1;
                exp_st = 0;
                @(posedge clk);
                release_reset();
            end else
                run(o, 3'($urandom), -1, 0);
        end
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
